cdb_arbiter: RTL

//  Buffered arbiter in front of the CDB broadcast bus. LSB and RS each push completed results
//  (RoB index + 32-bit value) into a private result queue. One winner per cycle is broadcast to
//  LSB/RS/RoB. Same-cycle completions from both sources therefore no longer collide.

---
 rtl/cdb_pkg.sv | 18 +
 rtl/cdb_result_queue.sv | 47 ++++
 rtl/cdb_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared types and sizes for the CDB arbiter (CDB_BYPASS_EN selects same-cycle bypass)
package cdb_pkg;

    localparam int RoB_WIDTH   = 3;
    localparam int QUEUE_AW    = 2;
    localparam int QUEUE_DEPTH = 1 << QUEUE_AW;

    typedef struct packed {
        logic [RoB_WIDTH-1:0] index;
        logic [31:0]          data;
    } cdb_entry_t;

    typedef enum logic {
        GRANT_LSB = 1'b0,
        GRANT_RS  = 1'b1
    } grant_t;

endpackage

// File: rtl/cdb_result_queue.sv
// rtl/cdb_result_queue.sv - per-source circular result FIFO feeding the CDB arbiter
module cdb_result_queue
    import cdb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t push_entry,
    input  logic       pop,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    cdb_entry_t             mem [QUEUE_DEPTH];
    logic [QUEUE_AW-1:0]    rd_ptr;
    logic [QUEUE_AW-1:0]    wr_ptr;
    logic [QUEUE_AW:0]      count;
    logic                   do_push;
    logic                   do_pop;

    // A push into a full queue is dropped even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{QUEUE_AW{1'b0}}, do_push} - {{QUEUE_AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush && do_push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (QUEUE_AW+1)'(QUEUE_DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin buffered arbiter onto the CDB; CDB_BYPASS_EN enables zero-latency bypass
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 LSB_update_en,
    input  logic [RoB_WIDTH-1:0] LSB_update_index,
    input  logic [31:0]          LSB_update_data,
    output logic                 LSB_full,
    input  logic                 RS_update_en,
    input  logic [RoB_WIDTH-1:0] RS_update_index,
    input  logic [31:0]          RS_update_data,
    output logic                 RS_full,
    output logic                 cdb_en,
    output logic [RoB_WIDTH-1:0] cdb_index,
    output logic [31:0]          cdb_data
);

    cdb_entry_t lsb_in, rs_in, lsb_head, rs_head, win_entry;
    logic       lsb_empty, rs_empty;
    logic       lsb_byp, rs_byp;
    logic       lsb_cand, rs_cand;
    logic       grant_rs, grant_lsb, grant_any;
    logic       lsb_push, rs_push, lsb_pop, rs_pop;
    logic       active;
    grant_t     last_grant;

    assign lsb_in = '{index: LSB_update_index, data: LSB_update_data};
    assign rs_in  = '{index: RS_update_index,  data: RS_update_data};
    assign active = rst_n_in && !flush_in && rdy_in;

`ifdef CDB_BYPASS_EN
    assign lsb_byp = lsb_empty && LSB_update_en;
    assign rs_byp  = rs_empty && RS_update_en;
`else
    assign lsb_byp = 1'b0;
    assign rs_byp  = 1'b0;
`endif

    assign lsb_cand = !lsb_empty || lsb_byp;
    assign rs_cand  = !rs_empty || rs_byp;

    // On a tie the source that did not win last time gets the bus.
    assign grant_rs  = rs_cand && (!lsb_cand || last_grant == GRANT_LSB);
    assign grant_lsb = lsb_cand && !grant_rs;
    assign grant_any = active && (lsb_cand || rs_cand);

    assign lsb_pop  = grant_any && grant_lsb && !lsb_empty;
    assign rs_pop   = grant_any && grant_rs && !rs_empty;
    // A bypassed result is consumed on the bus and must not also be queued.
    assign lsb_push = active && LSB_update_en && !(grant_any && grant_lsb && lsb_empty);
    assign rs_push  = active && RS_update_en && !(grant_any && grant_rs && rs_empty);

    assign win_entry = grant_rs ? (rs_empty ? rs_in : rs_head)
                                : (lsb_empty ? lsb_in : lsb_head);

    assign cdb_en    = grant_any;
    assign cdb_index = grant_any ? win_entry.index : '0;
    assign cdb_data  = grant_any ? win_entry.data : '0;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || flush_in) begin
            last_grant <= GRANT_LSB;
        end else if (grant_any) begin
            last_grant <= grant_rs ? GRANT_RS : GRANT_LSB;
        end
    end

    cdb_result_queue u_lsb_queue (
        .clk        (clk_in),
        .resetn     (rst_n_in),
        .flush      (flush_in),
        .push       (lsb_push),
        .push_entry (lsb_in),
        .pop        (lsb_pop),
        .head       (lsb_head),
        .empty      (lsb_empty),
        .full       (LSB_full)
    );

    cdb_result_queue u_rs_queue (
        .clk        (clk_in),
        .resetn     (rst_n_in),
        .flush      (flush_in),
        .push       (rs_push),
        .push_entry (rs_in),
        .pop        (rs_pop),
        .head       (rs_head),
        .empty      (rs_empty),
        .full       (RS_full)
    );

endmodule
